// File: rtl/riscv_wb_pkg.sv
// Shared types for the register-file writeback path.
package riscv_wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [XLEN-1:0]       data;
   } wb_req_t;

   // Which source drives the write port in the current cycle.
   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_ALU  = 2'd1,
      SEL_FIFO = 2'd2,
      SEL_MDU  = 2'd3
   } wb_src_e;

endpackage

// File: rtl/reg_writeback_arbiter_if.sv
// Bundle of the ALU, MDU and register-file write-port signals around the
// writeback arbiter. The arbiter uses the slave modport; the execute stage,
// the MDU and the register file together form the master side.
interface reg_writeback_arbiter_if;
   import riscv_wb_pkg::*;

   logic                  stall_reg_wr;
   logic                  alu_valid;
   logic [REG_ADDR_W-1:0] alu_rd_address;
   logic [XLEN-1:0]       alu_rd_data;
   logic                  alu_hold;
   logic                  mdu_valid;
   logic                  mdu_ready;
   logic [REG_ADDR_W-1:0] mdu_rd_address;
   logic [XLEN-1:0]       mdu_rd_data;
   logic                  mdu_pending;
   logic                  wr_rd_en;
   logic [REG_ADDR_W-1:0] rd_address;
   logic [XLEN-1:0]       rd_data;

   modport slave (
      input  stall_reg_wr, alu_valid, alu_rd_address, alu_rd_data,
      input  mdu_valid, mdu_rd_address, mdu_rd_data,
      output alu_hold, mdu_ready, mdu_pending,
      output wr_rd_en, rd_address, rd_data
   );

   modport master (
      output stall_reg_wr, alu_valid, alu_rd_address, alu_rd_data,
      output mdu_valid, mdu_rd_address, mdu_rd_data,
      input  alu_hold, mdu_ready, mdu_pending,
      input  wr_rd_en, rd_address, rd_data
   );

endinterface

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO holding MDU results until the write port is free.
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_result_fifo
   import riscv_wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    reset,
   input  logic    push,
   input  logic    pop,
   input  wb_req_t din,
   output logic    full,
   output logic    empty,
   output wb_req_t head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   wb_req_t          mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointer and occupancy bookkeeping; reset drops every stored entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/reg_writeback_arbiter.sv
// Merges single-cycle ALU results and buffered MUL/DIV results onto the one
// register-file write port. ALU has priority; a starvation counter forces
// the FIFO head through after STARVE_LIMIT consecutive losses.
// Optional feature macro: WB_BYPASS_EN -- an MDU result arriving while the
// port and FIFO are idle goes straight to the write port (1-cycle latency).
module reg_writeback_arbiter
   import riscv_wb_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input logic                  clk,
   input logic                  reset,
   reg_writeback_arbiter_if.slave bus
);

   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_push;
   logic                  fifo_pop;
   wb_req_t               fifo_head;
   wb_req_t               mdu_req;
   wb_req_t               alu_req;
   wb_req_t               sel_req;
   wb_src_e               sel_src;
   logic                  sel_valid;
   logic                  alu_hold_c;
   logic [CNT_W-1:0]      starve_cnt;
   logic                  wr_en_q;
   logic [REG_ADDR_W-1:0] rd_addr_q;
   logic [XLEN-1:0]       rd_data_q;

   assign mdu_req = '{rd: bus.mdu_rd_address, data: bus.mdu_rd_data};
   assign alu_req = '{rd: bus.alu_rd_address, data: bus.alu_rd_data};

   assign alu_hold_c = (starve_cnt == LIMIT) && !fifo_empty && !bus.stall_reg_wr;

   // Source priority: stall, forced FIFO drain, ALU, FIFO, optional bypass.
   always_comb begin
      sel_src = SEL_NONE;
      if (bus.stall_reg_wr)   sel_src = SEL_NONE;
      else if (alu_hold_c)    sel_src = SEL_FIFO;
      else if (bus.alu_valid) sel_src = SEL_ALU;
      else if (!fifo_empty)   sel_src = SEL_FIFO;
`ifdef WB_BYPASS_EN
      else if (bus.mdu_valid) sel_src = SEL_MDU;
`endif
   end

   // Data mux for the chosen source.
   always_comb begin
      sel_req = '0;
      case (sel_src)
         SEL_ALU:  sel_req = alu_req;
         SEL_FIFO: sel_req = fifo_head;
         SEL_MDU:  sel_req = mdu_req;
         default:  sel_req = '0;
      endcase
   end

   assign sel_valid = (sel_src != SEL_NONE);
   assign fifo_pop  = (sel_src == SEL_FIFO);
   // A bypassed MDU result is consumed directly and must not also be queued.
   assign fifo_push = bus.mdu_valid && !fifo_full && (sel_src != SEL_MDU);

   wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (mdu_req),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   // Count consecutive cycles the waiting FIFO head loses to the ALU.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         starve_cnt <= '0;
      end else if (fifo_empty || fifo_pop) begin
         starve_cnt <= '0;
      end else if ((sel_src == SEL_ALU) && (starve_cnt != LIMIT)) begin
         starve_cnt <= starve_cnt + CNT_W'(1);
      end
   end

   // Registered write port; x0 destinations are consumed without a strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_en_q   <= 1'b0;
         rd_addr_q <= '0;
         rd_data_q <= '0;
      end else begin
         wr_en_q <= sel_valid && (sel_req.rd != '0);
         if (sel_valid) begin
            rd_addr_q <= sel_req.rd;
            rd_data_q <= sel_req.data;
         end
      end
   end

   assign bus.alu_hold    = alu_hold_c;
   assign bus.mdu_ready   = !fifo_full;
   assign bus.mdu_pending = !fifo_empty;
   assign bus.wr_rd_en    = wr_en_q;
   assign bus.rd_address  = rd_addr_q;
   assign bus.rd_data     = rd_data_q;

endmodule
